alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised multi-cycle successor to the team's combinational 16-bit ALU. It is used by the execute stage of the custom MIPS core.
- Single-cycle ops (add/sub/logic/compare/shift) return a registered result one cycle after issue.
- Unsigned multiply (shift-add) and unsigned divide (restoring) iterate for WIDTH cycles.
- Issue uses a start/ready handshake; completion is a one-cycle done pulse.
- The block produces a registered status-flag vector and a high-half result port (mul high word / div remainder).

Parameters:
WIDTH, 16, datapath width in bits (>=4, power of two).
SHW, $clog2(WIDTH), derived shift-amount width (localparam, not overridable).

Ports:
clk  input  1  rising-edge clock, single clock domain.
rst  input  1  synchronous, active-high reset.
start  input  1  issue request; sampled only when ready=1.
aluctrl  input  4  opcode (see encoding).
din1  input  WIDTH  operand A.
din2  input  WIDTH  operand B / shift amount.
ready  output  1  block can accept start this cycle.
done  output  1  one-cycle pulse: dout/dout_hi/flags just updated.
dout  output  WIDTH  result (low word / quotient).
dout_hi  output  WIDTH  mul high word, div remainder, else 0.
flags  output  6  {DZ,P,V,C,N,Z}, bit0=Z.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Opcode encoding: 0000 isneq, 0001 add, 0010 sub, 0011 mul, 0100 islt, 0101 iseq, 0110 or, 0111 and, 1000 mv, 1001 xor, 1010 not, 1011 sll, 1100 isgt, 1101 srl, 1110 sra, 1111 divu. The encoding is total, with no duplicate codes.
- Reset: state=IDLE, ready=1, done=0, dout=0, dout_hi=0, flags=0. Reset wins over start in the same cycle and aborts any iteration in progress without a done pulse.
- States:
  - IDLE: start&ready at edge N:
    - single-cycle op: result, flags registered at edge N; done=1 in cycle N+1; state stays IDLE.
    - mul: operands latched, go to MUL, cnt=0.
    - divu with din2!=0: operands latched, go to DIV, cnt=0.
    - divu with din2==0: dout=all-ones, dout_hi=din1, DZ=1, done in cycle N+1, stays IDLE.
  - MUL/DIV: one iteration per edge. After WIDTH iterations (edge N+WIDTH), register result and flags, return to IDLE, done=1 in that following cycle.
  - ready=0 from cycle N+1 to the last iteration cycle. ready=1 again in the done cycle, so back-to-back issue is legal.
- start while ready=0 is ignored; it is neither queued nor an error.
- dout, dout_hi and flags hold their values between done pulses. done never asserts for two consecutive cycles from a single issue.
- Arithmetic (all WIDTH-bit, wrap-around):
  - add/sub: C = carry-out (add) or borrow (sub, din1<din2 unsigned); V = two's-complement signed overflow.
  - Compares are unsigned and return 1 or 0 in dout: islt is strict din1<din2; isgt is din1>din2.
  - Shifts use din2 as the amount. If din2>=WIDTH: sll/srl give 0, sra gives sign fill (all-ones or 0).
  - mul: {dout_hi,dout} = din1*din2 (2*WIDTH product); V=1 iff dout_hi!=0.
  - divu: dout=quotient, dout_hi=remainder.
- Flags are updated only at completion.
  - Z = (dout==0); N = dout[WIDTH-1]; P = ^dout (XOR reduction).
  - C and V are 0 for ops that do not define them; DZ is 0 except for divide-by-zero.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_DIVU);
  - flag bit indices (FLG_Z..FLG_DZ);
  - the state enum {IDLE, MUL, DIV}.
- One sub-module, alu_iter, contains the shared shift-add/restoring-divide datapath: accumulator, counter and mode input. Its interface is start/busy/last.
- Single-cycle ops and the FSM stay in alu_mc.

Test Plan:
1. add 0xFFFF+0x0001 -> done in cycle after issue, dout=0x0000, Z=1, C=1, V=0, P=0. Then sub 0x8000-0x0001 -> dout=0x7FFF, V=1, C=0.
2. mul 0x1234*0x0100 -> dout=0x3400, dout_hi=0x0012, V=1. done exactly 16 cycles after the issue edge; ready=0 for 15 cycles; a start pulse with add inside the busy window is ignored (no extra done).
3. divu 100/7 -> dout=14, dout_hi=2, DZ=0 after 16 cycles. divu 0x1234/0 -> next cycle dout=0xFFFF, dout_hi=0x1234, DZ=1.
4. Shifts:
   - sll 0x0001 by 15 -> 0x8000, N=1.
   - srl 0x8000 by 20 -> 0x0000, Z=1.
   - sra 0x8000 by 3 -> 0xF000.
   - sra 0x8000 by 16 -> 0xFFFF.
5. Compares: islt 3,3 -> 0; isgt 5,3 -> 1; isneq 7,7 -> 0; iseq 7,7 -> 1. Each is a single-cycle done with C=V=DZ=0.
6. rst high at iteration 5 of mul -> next cycle ready=1, done=0, dout=dout_hi=flags=0, no later done. A fresh add issued immediately completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, flag indices and FSM states
// for the multi-cycle execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_ISNEQ = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] OP_ISLT  = 4'b0100;
  localparam logic [3:0] OP_ISEQ  = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_MV    = 4'b1000;
  localparam logic [3:0] OP_XOR   = 4'b1001;
  localparam logic [3:0] OP_NOT   = 4'b1010;
  localparam logic [3:0] OP_SLL   = 4'b1011;
  localparam logic [3:0] OP_ISGT  = 4'b1100;
  localparam logic [3:0] OP_SRL   = 4'b1101;
  localparam logic [3:0] OP_SRA   = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  localparam int FLG_Z  = 0;
  localparam int FLG_N  = 1;
  localparam int FLG_C  = 2;
  localparam int FLG_V  = 3;
  localparam int FLG_P  = 4;
  localparam int FLG_DZ = 5;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

endpackage

// File: rtl/alu_iter.sv
// Shared iterative datapath: shift-add multiply
// (mode=0) and restoring unsigned divide (mode=1).
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] nxt_lo,
  output logic [WIDTH-1:0] nxt_hi
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  assign last = busy && (cnt == SHW'(WIDTH - 1));

  // diff[WIDTH] is the borrow: partial remainder < divisor
  always_comb begin
    sum  = {1'b0, hi} + {1'b0, {WIDTH{lo[0]}} & opb};
    sh   = {hi, lo[WIDTH-1]};
    diff = sh - {1'b0, opb};
    if (mode) begin
      if (!diff[WIDTH]) begin
        nxt_hi = diff[WIDTH-1:0];
        nxt_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = sh[WIDTH-1:0];
        nxt_lo = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      opb  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      hi   <= '0;
      lo   <= a;
      opb  <= b;
    end else if (busy) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt + SHW'(1);
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered single-cycle ops,
// iterative mul/divu, start/ready issue, done pulse.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluctrl,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_hi,
  output logic [5:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  state_t state;
  state_t state_nxt;

  logic [SHW-1:0] shamt;
  logic big;
  logic [WIDTH-1:0] sc_lo;
  logic [WIDTH-1:0] sc_hi;
  logic sc_c;
  logic sc_v;
  logic sc_dz;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic r_c;
  logic r_v;
  logic r_dz;
  logic [5:0] fl;
  logic ld;
  logic it_start;
  logic it_busy;
  logic it_last;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH-1:0] nxt_hi;

  assign shamt = din2[SHW-1:0];
  assign big   = |din2[WIDTH-1:SHW];
  assign ready = (state == IDLE) && !it_busy;

  alu_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (it_start),
    .mode  (state == DIV),
    .a     (din1),
    .b     (din2),
    .busy  (it_busy),
    .last  (it_last),
    .nxt_lo(nxt_lo),
    .nxt_hi(nxt_hi)
  );

  always_comb begin
    sc_lo = '0;
    sc_hi = '0;
    sc_c  = 1'b0;
    sc_v  = 1'b0;
    sc_dz = 1'b0;
    unique case (aluctrl)
      OP_ISNEQ: sc_lo = WIDTH'(din1 != din2);
      OP_ADD: begin
        {sc_c, sc_lo} = {1'b0, din1} + {1'b0, din2};
        sc_v = (din1[WIDTH-1] == din2[WIDTH-1]) &&
               (sc_lo[WIDTH-1] != din1[WIDTH-1]);
      end
      OP_SUB: begin
        {sc_c, sc_lo} = {1'b0, din1} - {1'b0, din2};
        sc_v = (din1[WIDTH-1] != din2[WIDTH-1]) &&
               (sc_lo[WIDTH-1] != din1[WIDTH-1]);
      end
      OP_MUL:  sc_lo = '0;
      OP_ISLT: sc_lo = WIDTH'(din1 < din2);
      OP_ISEQ: sc_lo = WIDTH'(din1 == din2);
      OP_OR:   sc_lo = din1 | din2;
      OP_AND:  sc_lo = din1 & din2;
      OP_MV:   sc_lo = din1;
      OP_XOR:  sc_lo = din1 ^ din2;
      OP_NOT:  sc_lo = ~din1;
      OP_SLL:  sc_lo = big ? '0 : din1 << shamt;
      OP_ISGT: sc_lo = WIDTH'(din1 > din2);
      OP_SRL:  sc_lo = big ? '0 : din1 >> shamt;
      OP_SRA: begin
        if (big) sc_lo = {WIDTH{din1[WIDTH-1]}};
        else     sc_lo = $signed(din1) >>> shamt;
      end
      OP_DIVU: begin
        // only reached as a result for a zero divisor
        sc_lo = '1;
        sc_hi = din1;
        sc_dz = 1'b1;
      end
      default: sc_lo = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    it_start  = 1'b0;
    ld        = 1'b0;
    r_lo      = sc_lo;
    r_hi      = sc_hi;
    r_c       = sc_c;
    r_v       = sc_v;
    r_dz      = sc_dz;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (aluctrl == OP_MUL) begin
            it_start  = 1'b1;
            state_nxt = MUL;
          end else if (aluctrl == OP_DIVU && din2 != '0) begin
            it_start  = 1'b1;
            state_nxt = DIV;
          end else begin
            ld = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        r_lo = nxt_lo;
        r_hi = nxt_hi;
        r_c  = 1'b0;
        r_v  = (state == MUL) && (|nxt_hi);
        r_dz = 1'b0;
        if (it_last) begin
          ld        = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fl         = '0;
    fl[FLG_Z]  = (r_lo == '0);
    fl[FLG_N]  = r_lo[WIDTH-1];
    fl[FLG_C]  = r_c;
    fl[FLG_V]  = r_v;
    fl[FLG_P]  = ^r_lo;
    fl[FLG_DZ] = r_dz;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done    <= 1'b0;
      dout    <= '0;
      dout_hi <= '0;
      flags   <= '0;
    end else begin
      done <= ld;
      if (ld) begin
        dout    <= r_lo;
        dout_hi <= r_hi;
        flags   <= fl;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc
// with hand-computed expected results.
module tb_alu_mc;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] aluctrl = 4'h0;
  logic [15:0] din1 = 16'h0;
  logic [15:0] din2 = 16'h0;
  logic ready;
  logic done;
  logic [15:0] dout;
  logic [15:0] dout_hi;
  logic [5:0] flags;
  logic [38:0] obs;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .aluctrl(aluctrl),
    .din1   (din1),
    .din2   (din2),
    .ready  (ready),
    .done   (done),
    .dout   (dout),
    .dout_hi(dout_hi),
    .flags  (flags)
  );

  assign obs = {done, dout, dout_hi, flags};

  task automatic issue(input logic [3:0] op,
                       input logic [15:0] a,
                       input logic [15:0] b);
    @(negedge clk);
    aluctrl = op;
    din1 = a;
    din2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [39:0] exp;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp = {1'b1, 1'b0, 16'h0, 16'h0, 6'h00};
    ncmp++;
    if ({ready, obs} !== exp) begin
      nfail++;
      $display("FAIL reset got %h exp %h", {ready, obs}, exp);
    end
  endtask

  task automatic test_single();
    logic [3:0] op [19] = '{OP_ADD, OP_SUB, OP_ADD, OP_SUB,
      OP_SLL, OP_SLL, OP_SRL, OP_SRA, OP_SRA, OP_ISLT,
      OP_ISGT, OP_ISNEQ, OP_ISEQ, OP_AND, OP_OR, OP_XOR,
      OP_NOT, OP_ISLT, OP_ADD};
    logic [15:0] a [19] = '{16'hFFFF, 16'h8000, 16'h7FFF,
      16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h8000,
      16'h8000, 16'h0003, 16'h0005, 16'h0007, 16'h0007,
      16'hF0F0, 16'h0F00, 16'h1200, 16'h00FF, 16'h0002,
      16'h0002};
    logic [15:0] b [19] = '{16'h0001, 16'h0001, 16'h0001,
      16'h0002, 16'h000F, 16'h0010, 16'h0014, 16'h0003,
      16'h0010, 16'h0003, 16'h0003, 16'h0007, 16'h0007,
      16'hFF00, 16'h00F0, 16'h0034, 16'h0000, 16'h0003,
      16'h0003};
    logic [15:0] r [19] = '{16'h0000, 16'h7FFF, 16'h8000,
      16'hFFFF, 16'h8000, 16'h0000, 16'h0000, 16'hF000,
      16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h0001,
      16'hF000, 16'h0FF0, 16'h1234, 16'hFF00, 16'h0001,
      16'h0005};
    logic [5:0] f [19] = '{6'h05, 6'h18, 6'h1A, 6'h06,
      6'h12, 6'h01, 6'h01, 6'h02, 6'h02, 6'h01, 6'h10,
      6'h01, 6'h10, 6'h02, 6'h00, 6'h10, 6'h02, 6'h10,
      6'h00};
    logic [38:0] exp;
    for (int i = 0; i < 19; i++) begin
      issue(op[i], a[i], b[i]);
      exp = {1'b1, r[i], 16'h0, f[i]};
      ncmp++;
      if (obs !== exp) begin
        nfail++;
        $display("FAIL single[%0d] op %h got %h exp %h",
                 i, op[i], obs, exp);
      end
    end
  endtask

  task automatic test_mul();
    logic [38:0] exp;
    int bad;
    int extra;
    bad = 0;
    issue(OP_MUL, 16'h1234, 16'h0100);
    if (ready !== 1'b0 || done !== 1'b0) bad++;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) begin
        aluctrl = OP_ADD;
        din1 = 16'h0001;
        din2 = 16'h0001;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k < 16 && (ready !== 1'b0 || done !== 1'b0)) bad++;
    end
    ncmp++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL mul_busy got %0d bad cycles exp 0", bad);
    end
    exp = {1'b1, 16'h3400, 16'h0012, 6'h18};
    ncmp++;
    if ({ready, obs} !== {1'b1, exp}) begin
      nfail++;
      $display("FAIL mul_done got %h exp %h",
               {ready, obs}, {1'b1, exp});
    end
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) extra++;
    end
    ncmp++;
    if (extra != 0 || dout !== 16'h3400) begin
      nfail++;
      $display("FAIL mul_hold got %0d dones dout %h exp 0 3400",
               extra, dout);
    end
  endtask

  task automatic test_div();
    logic [38:0] exp;
    int cyc;
    issue(OP_DIVU, 16'd100, 16'd7);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    exp = {1'b1, 16'd14, 16'd2, 6'h10};
    ncmp++;
    if (cyc != 16 || obs !== exp) begin
      nfail++;
      $display("FAIL div got %h after %0d exp %h after 16",
               obs, cyc, exp);
    end
    issue(OP_ADD, 16'h7FFF, 16'h0001);
    exp = {1'b1, 16'h8000, 16'h0000, 6'h1A};
    ncmp++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL back_to_back got %h exp %h", obs, exp);
    end
    issue(OP_DIVU, 16'h1234, 16'h0000);
    exp = {1'b1, 16'hFFFF, 16'h1234, 6'h22};
    ncmp++;
    if ({ready, obs} !== {1'b1, exp}) begin
      nfail++;
      $display("FAIL div_zero got %h exp %h",
               {ready, obs}, {1'b1, exp});
    end
  endtask

  task automatic test_abort();
    logic [39:0] exp;
    int extra;
    issue(OP_MUL, 16'hFFFF, 16'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b1;
    aluctrl = OP_ADD;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    exp = {1'b1, 1'b0, 16'h0, 16'h0, 6'h00};
    ncmp++;
    if ({ready, obs} !== exp) begin
      nfail++;
      $display("FAIL abort got %h exp %h", {ready, obs}, exp);
    end
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) extra++;
    end
    ncmp++;
    if (extra != 0) begin
      nfail++;
      $display("FAIL abort_nodone got %0d dones exp 0", extra);
    end
    issue(OP_ADD, 16'h0002, 16'h0003);
    ncmp++;
    if (obs !== {1'b1, 16'h0005, 16'h0000, 6'h00}) begin
      nfail++;
      $display("FAIL abort_add got %h exp %h", obs,
               {1'b1, 16'h0005, 16'h0000, 6'h00});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
